// File: rtl/psum_spad.sv
// psum_spad: parametrised partial-sum scratchpad for the PE.
// Registered read with valid flag, write-first bypass, accumulate-on-write,
// and a sequenced zeroing sweep driven by a two-state FSM.
// Optional macro PSUM_SPAD_SAT_EN: accumulate becomes a signed saturating add;
// without it the accumulate wraps modulo 2**DATA_W.
module psum_spad #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              clr_,
  input  logic              wr_en,
  input  logic              acc_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              zero_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic        [ADDR_W-1:0]  r_cnt;
  logic signed [DATA_W-1:0]  r_mem [DEPTH];
  logic        [DATA_W-1:0]  r_rd_data;
  logic                      r_rd_valid;

  logic                      w_idle;
  logic                      w_wr_active;
  logic                      w_rd_active;
  logic signed [DATA_W-1:0]  w_wr_val;

  // Accumulate adder: saturating when the macro is defined, wrapping otherwise.
  function automatic logic signed [DATA_W-1:0] acc_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
`ifdef PSUM_SPAD_SAT_EN
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Sign of the extended sum disagreeing with its top data bit means overflow.
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      return s[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign w_idle      = (r_state == IDLE);
  assign w_wr_active = w_idle && wr_en;
  assign w_rd_active = w_idle && rd_en;
  // Value landing in the entry this cycle; also the bypass source for reads.
  assign w_wr_val    = acc_en ? acc_add(r_mem[wr_addr], $signed(wr_data))
                              : $signed(wr_data);

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = (r_state == SWEEP);

  // FSM state register.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: a zero request starts the sweep, the last entry ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (zero_req) w_state_nxt = SWEEP;
      SWEEP:   if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sweep counter: advances once per sweep cycle and wraps back to 0 at the end.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_)                r_cnt <= '0;
    else if (r_state == SWEEP) r_cnt <= r_cnt + 1'b1;
  end

  // Storage array: sweep clears one entry per cycle, otherwise write/accumulate.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == SWEEP) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_active) begin
      r_mem[wr_addr] <= w_wr_val;
    end
  end

  // Registered read port with write-first bypass on an address match.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_active;
      if (w_rd_active) begin
        if (w_wr_active && (wr_addr == rd_addr)) r_rd_data <= w_wr_val;
        else                                     r_rd_data <= r_mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_psum_spad.sv
// Self-checking bench for psum_spad: behavioural model plus directed literals
// and a randomized phase. Honours PSUM_SPAD_SAT_EN for the overflow expectations.
module tb_psum_spad;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK;
  logic          clr_;
  logic          wr_en, acc_en, rd_en, zero_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] e_rd_data  = '0;
  logic          e_rd_valid = 1'b0;
  int            sweep_left = 0;

  psum_spad #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK      (CLK),
    .clr_     (clr_),
    .wr_en    (wr_en),
    .acc_en   (acc_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .zero_req (zero_req),
    .busy     (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_acc(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SPAD_SAT_EN
    if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
    if (s < -(1 << (DW - 1)))    s = -(1 << (DW - 1));
`endif
    return s[DW-1:0];
  endfunction

  // Behavioural model: sweep counts down remaining entries; otherwise write, then read.
  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    forever begin
      @(posedge CLK or negedge clr_);
      if (!clr_) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        e_rd_data  = '0;
        e_rd_valid = 1'b0;
        sweep_left = 0;
      end else if (sweep_left > 0) begin
        m_mem[DEPTH - sweep_left] = '0;
        sweep_left--;
        e_rd_valid = 1'b0;
      end else begin
        if (wr_en) m_mem[wr_addr] = acc_en ? m_acc(m_mem[wr_addr], wr_data) : wr_data;
        if (rd_en) begin
          e_rd_data  = m_mem[rd_addr];
          e_rd_valid = 1'b1;
        end else begin
          e_rd_valid = 1'b0;
        end
        if (zero_req) sweep_left = DEPTH;
      end
    end
  end

  // Compare process: outputs against the model every cycle outside reset.
  initial begin
    forever begin
      @(negedge CLK);
      if (clr_ === 1'b1) begin
        chk("model_rd_valid", 32'(rd_valid), 32'(e_rd_valid));
        chk("model_busy", 32'(busy), 32'(sweep_left > 0));
        chk("model_rd_data", 32'(rd_data), 32'(e_rd_data));
      end
    end
  end

  task automatic step(input logic we, input logic ac, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic zr);
    wr_en = we; acc_en = ac; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; zero_req = zr;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int bc;
    logic [DW-1:0] exp_ov;
    clr_ = 1'b0;
    wr_en = 0; acc_en = 0; rd_en = 0; zero_req = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge CLK);
    clr_ = 1'b1;

    // Test 1: asynchronous reset in the middle of a sweep.
    step(1, 0, 4'd0, 16'h55AA, 0, 4'd0, 0);
    step(1, 0, 4'd9, 16'h1111, 1, 4'd0, 0);
    chk("t1_pre_rd", 32'(rd_data), 32'h55AA);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 1);
    repeat (4) idle();
    chk("t1_busy_mid", 32'(busy), 32'h1);
    #2 clr_ = 1'b0;
    #1;
    chk("t1_async_rd_data", 32'(rd_data), 32'h0);
    chk("t1_async_rd_valid", 32'(rd_valid), 32'h0);
    chk("t1_async_busy", 32'(busy), 32'h0);
    @(negedge CLK);
    clr_ = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 0, 4'd0, 16'h0, 1, AW'(a), 0);
      chk("t1_zero_rd", 32'(rd_data), 32'h0);
      chk("t1_zero_vld", 32'(rd_valid), 32'h1);
    end

    // Test 2: write then read, then hold.
    step(1, 0, 4'd3, 16'h1234, 0, 4'd0, 0);
    step(0, 0, 4'd0, 16'h0, 1, 4'd3, 0);
    chk("t2_rd", 32'(rd_data), 32'h1234);
    chk("t2_vld", 32'(rd_valid), 32'h1);
    idle();
    chk("t2_vld_low", 32'(rd_valid), 32'h0);
    chk("t2_hold", 32'(rd_data), 32'h1234);

    // Test 3: back-to-back accumulate.
    step(1, 0, 4'd5, 16'h0010, 0, 4'd0, 0);
    step(1, 1, 4'd5, 16'h0005, 0, 4'd0, 0);
    step(1, 1, 4'd5, 16'h0005, 0, 4'd0, 0);
    step(0, 0, 4'd0, 16'h0, 1, 4'd5, 0);
    chk("t3_acc", 32'(rd_data), 32'h001A);

    // Test 4: write-first bypass for write and accumulate.
    step(1, 0, 4'd7, 16'hBEEF, 1, 4'd7, 0);
    chk("t4_bypass_wr", 32'(rd_data), 32'hBEEF);
    step(1, 1, 4'd7, 16'h0001, 1, 4'd7, 0);
    chk("t4_bypass_acc", 32'(rd_data), 32'hBEF0);

    // Test 5: fill, sweep with an ignored write, read back zeros.
    for (int a = 0; a < DEPTH; a++) step(1, 0, AW'(a), 16'hFFFF, 0, 4'd0, 0);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 1);
    bc = busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) step(1, 0, 4'd2, 16'hAAAA, 1, 4'd2, 1);
      else         idle();
      if (busy) bc++;
    end
    chk("t5_busy_cycles", 32'(bc), 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 0, 4'd0, 16'h0, 1, AW'(a), 0);
      chk("t5_swept", 32'(rd_data), 32'h0);
    end

    // Test 6: overflow behaviour.
`ifdef PSUM_SPAD_SAT_EN
    exp_ov = 16'h7FFF;
`else
    exp_ov = 16'h8000;
`endif
    step(1, 0, 4'd0, 16'h7FFF, 0, 4'd0, 0);
    step(1, 1, 4'd0, 16'h0001, 0, 4'd0, 0);
    step(0, 0, 4'd0, 16'h0, 1, 4'd0, 0);
    chk("t6_pos_ovf", 32'(rd_data), 32'(exp_ov));
`ifdef PSUM_SPAD_SAT_EN
    exp_ov = 16'h8000;
`else
    exp_ov = 16'h7FFF;
`endif
    step(1, 0, 4'd1, 16'h8000, 0, 4'd0, 0);
    step(1, 1, 4'd1, 16'hFFFF, 0, 4'd0, 0);
    step(0, 0, 4'd0, 16'h0, 1, 4'd1, 0);
    chk("t6_neg_ovf", 32'(rd_data), 32'(exp_ov));

    // Randomized phase, model-checked every cycle.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       wd = 16'h7FFF;
        1:       wd = 16'h8000;
        default: wd = DW'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, wd,
           1'($urandom_range(0, 1)), ra, ($urandom_range(0, 59) == 0));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
